seq_divider8: RTL and testbench

Sequential unsigned restoring divider: the inverse datapath of the team's 8×8 carry-save array multiplier. It accepts a dividend/divisor pair on a start pulse and iterates one quotient bit per clock. It returns quotient and remainder with a single-cycle done pulse. It sits next to the multiplier in the arithmetic unit and shares its operand width, so a multiply result's low byte can be checked by dividing back.

---
 rtl/div_pkg.sv | 17 +
 rtl/seq_divider8_if.sv | 30 +++
 rtl/div_trial_sub.sv | 32 +++
 rtl/fulladder.sv | 14 +
 rtl/seq_divider8.sv | 113 +++++++++++
 tb/tb_seq_divider8.sv | 177 +++++++++++++++++
 6 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Holds the FSM state enum, default width and divide-by-zero quotient.
package div_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int MAX_WIDTH = 16;

  // Quotient reported for x / 0; sliced down to the instance width.
  localparam logic [MAX_WIDTH-1:0] DBZ_QUOT = '1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/seq_divider8_if.sv
// Divider request/result bundle.
// master drives start/dividend/divisor; slave returns busy/done/results.
interface seq_divider8_if
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient,
    input  remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient,
    output remainder, div_by_zero
  );

endinterface

// File: rtl/div_trial_sub.sv
// WIDTH+1-bit ripple trial subtractor: minuend - {0,subtrahend}.
// Ports: minuend, subtrahend in; diff (low WIDTH bits), neg (sign) out.
module div_trial_sub
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH:0]   minuend,
  input  logic [WIDTH-1:0] subtrahend,
  output logic [WIDTH-1:0] diff,
  output logic             neg
);

  logic [WIDTH:0] c;

  assign c[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    fulladder u_fa (
      .a  (minuend[i]),
      .b  (~subtrahend[i]),
      .ci (c[i]),
      .s  (diff[i]),
      .co (c[i+1])
    );
  end

  // Top bit subtracts the zero extension (inverted to 1);
  // its carry-out is not needed, only the sign.
  assign neg = ~(minuend[WIDTH] ^ c[WIDTH]);

endmodule

// File: rtl/fulladder.sv
// One-bit full adder cell.
// Ports: a, b, ci in; s (sum), co (carry) out.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/seq_divider8.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Ports: clk, rst (sync, high), bus (slave: start/operands in, results out).
module seq_divider8
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic           clk,
  input logic           rst,
  seq_divider8_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   r_sh;
  logic [WIDTH-1:0] diff;
  logic             neg;

  // Partial remainder stays below the divisor, so its top bit
  // is always zero and only WIDTH bits are stored.
  assign r_sh = {r_q, q_q[WIDTH-1]};

  div_trial_sub #(
    .WIDTH (WIDTH)
  ) u_sub (
    .minuend    (r_sh),
    .subtrahend (dvs_q),
    .diff       (diff),
    .neg        (neg)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          dvs_d = bus.divisor;
          q_d   = bus.dividend;
          r_d   = '0;
          if (bus.divisor == '0) begin
            state_d = DONE;
            cnt_d   = '0;
            quo_d   = DBZ_QUOT[WIDTH-1:0];
            rem_d   = bus.dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = RUN;
            cnt_d   = CW'(WIDTH - 1);
          end
        end
      end
      RUN: begin
        r_d = neg ? r_sh[WIDTH-1:0] : diff;
        q_d = {q_q[WIDTH-2:0], ~neg};
        if (cnt_q == '0) begin
          state_d = DONE;
          quo_d   = q_d;
          rem_d   = r_d;
          dbz_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy        = (state_q == RUN);
  assign bus.done        = (state_q == DONE);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider8.sv
// Self-checking bench for seq_divider8: vector table, corner sequences,
// and a random sweep against plain integer division.
module tb_seq_divider8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seq_divider8_if #(.WIDTH(8)) bus ();

  seq_divider8 #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int dbz;
    int lat;
    int busy_n;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Wait (bounded) for done; counts edges and busy samples on the way.
  task automatic wait_done(input int bound, output int edges,
                           output int busy_n);
    edges = 0;
    busy_n = 0;
    while (!bus.done && edges < bound) begin
      if (bus.busy) busy_n++;
      tick();
      edges++;
    end
    if (!bus.done) chk("done_timeout", 0, 1);
  endtask

  task automatic start_op(input int a, input int b);
    bus.start = 1'b1;
    bus.dividend = 8'(a);
    bus.divisor = 8'(b);
    tick();
    bus.start = 1'b0;
  endtask

  int lat, bn, dn, q_hold;
  int a, b, eq, er;
  int got_q, got_r;

  initial begin
    vecs[0] = '{100, 7,  14,  2,   0, 8, 8};
    vecs[1] = '{255, 1,  255, 0,   0, 8, 8};
    vecs[2] = '{5,   200, 0,  5,   0, 8, 8};
    vecs[3] = '{200, 200, 1,  0,   0, 8, 8};
    vecs[4] = '{77,  0,  255, 77,  1, 0, 0};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_quot", int'(bus.quotient), 0);
    chk("rst_rem", int'(bus.remainder), 0);
    chk("rst_dbz", int'(bus.div_by_zero), 0);

    for (int i = 0; i < 5; i++) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_done(20, lat, bn);
      chk($sformatf("v%0d_quot", i), int'(bus.quotient), vecs[i].q);
      chk($sformatf("v%0d_rem", i), int'(bus.remainder), vecs[i].r);
      chk($sformatf("v%0d_dbz", i), int'(bus.div_by_zero), vecs[i].dbz);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_busy", i), bn, vecs[i].busy_n);
      tick();
      chk($sformatf("v%0d_pulse", i), int'(bus.done), 0);
      chk($sformatf("v%0d_hold", i), int'(bus.quotient), vecs[i].q);
    end

    // start while busy is ignored; start in done cycle is taken
    start_op(100, 7);
    bus.start = 1'b1;
    bus.dividend = 8'd9;
    bus.divisor = 8'd3;
    for (int k = 0; k < 4; k++) tick();
    bus.start = 1'b0;
    wait_done(20, lat, bn);
    chk("ign_lat", lat + 4, 8);
    chk("ign_quot", int'(bus.quotient), 14);
    chk("ign_rem", int'(bus.remainder), 2);
    start_op(9, 3);
    chk("b2b_busy", int'(bus.busy), 1);
    chk("b2b_hold", int'(bus.quotient), 14);
    wait_done(20, lat, bn);
    chk("b2b_lat", lat, 8);
    chk("b2b_quot", int'(bus.quotient), 3);
    chk("b2b_rem", int'(bus.remainder), 0);
    tick();

    // reset mid-run discards the division
    start_op(250, 9);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", int'(bus.busy), 0);
    chk("mrst_done", int'(bus.done), 0);
    chk("mrst_quot", int'(bus.quotient), 0);
    chk("mrst_rem", int'(bus.remainder), 0);
    chk("mrst_dbz", int'(bus.div_by_zero), 0);
    dn = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus.done) dn++;
      tick();
    end
    chk("mrst_nodone", dn, 0);
    start_op(250, 9);
    wait_done(20, lat, bn);
    chk("post_quot", int'(bus.quotient), 27);
    chk("post_rem", int'(bus.remainder), 7);
    tick();

    // random sweep over every nonzero divisor
    for (int i = 0; i < 2000; i++) begin
      b = (i % 255) + 1;
      a = int'($urandom_range(0, 255));
      eq = a / b;
      er = a % b;
      start_op(a, b);
      dn = 0;
      got_q = -1;
      got_r = -1;
      for (int k = 0; k < 12; k++) begin
        if (bus.done) begin
          dn++;
          got_q = int'(bus.quotient);
          got_r = int'(bus.remainder);
        end
        tick();
      end
      chk($sformatf("rnd%0d_ndone", i), dn, 1);
      chk($sformatf("rnd%0d_quot", i), got_q, eq);
      chk($sformatf("rnd%0d_rem", i), got_r, er);
      chk($sformatf("rnd%0d_inv", i), got_q * b + got_r, a);
      chk($sformatf("rnd%0d_rlt", i), int'(got_r < b), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
